// File: rtl/fir_arb_pkg.sv
// Shared types and constants for the FIR channel arbiter.
package fir_arb_pkg;

    localparam int SAMPLE_W      = 16;
    localparam int DEF_START_TMO = 4;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_START,
        WAIT_DONE,
        RESULT,
        COEFF_ISSUE,
        COEFF_WAIT_START,
        COEFF_WAIT_DONE
    } arb_state_t;

endpackage

// File: rtl/fir_channel_arbiter_rr_grant.sv
// Round-robin picker: first requester after the last granted channel wins.
module rr_grant #(
    parameter int NUM_CH = 2,
    parameter int CH_W   = 2
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [NUM_CH-1:0] req,
    input  logic              advance,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   grant_idx
);

    logic [CH_W-1:0] ptr;
    logic [CH_W-1:0] hi_idx;
    logic [CH_W-1:0] lo_idx;
    logic            hi_found;
    logic            lo_found;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_found = 1'b0;
        lo_idx   = '0;
        // Walk downwards so the lowest qualifying index is the last one written.
        for (int j = NUM_CH - 1; j >= 0; j--) begin
            if (req[j]) begin
                lo_found = 1'b1;
                lo_idx   = CH_W'(j);
                if (CH_W'(j) > ptr) begin
                    hi_found = 1'b1;
                    hi_idx   = CH_W'(j);
                end
            end
        end
        grant_idx = hi_found ? hi_idx : lo_idx;
        grant     = '0;
        for (int j = 0; j < NUM_CH; j++) begin
            grant[j] = lo_found && (CH_W'(j) == grant_idx);
        end
    end

    // Pointer starts on the last channel so channel 0 is served first.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            ptr <= CH_W'(NUM_CH - 1);
        end else if (advance) begin
            ptr <= grant_idx;
        end
    end

endmodule

// File: rtl/fir_channel_arbiter.sv
// Shares one FIR datapath between NUM_CH sample streams and the coefficient loader.
module fir_channel_arbiter
    import fir_arb_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int CH_W      = 2,
    parameter int START_TMO = DEF_START_TMO
) (
    input  logic                             clk,
    input  logic                             n_rst,
    input  logic [NUM_CH-1:0]                req_valid,
    input  logic [NUM_CH-1:0][SAMPLE_W-1:0]  req_data,
    output logic [NUM_CH-1:0]                req_ready,
    input  logic                             coeff_req,
    output logic                             coeff_start,
    input  logic                             modwait,
    input  logic [SAMPLE_W-1:0]              fir_out,
    input  logic                             err,
    output logic [SAMPLE_W-1:0]              sample_data,
    output logic                             data_ready,
    output logic                             res_valid,
    output logic [SAMPLE_W-1:0]              res_data,
    output logic                             res_err,
    output logic [CH_W-1:0]                  res_ch,
    input  logic                             res_ready,
    output logic                             tmo_err
);

    localparam int TMO_W = $clog2(START_TMO + 1);

    arb_state_t          state;
    logic [NUM_CH-1:0]   grant;
    logic [CH_W-1:0]     grant_idx;
    logic [CH_W-1:0]     cur_ch;
    logic [SAMPLE_W-1:0] grant_data;
    logic [TMO_W-1:0]    tmo_cnt;
    logic                accept_en;
    logic                accept;
    logic                tmo_hit;

    // No transfer while in reset, so nothing is accepted that would be dropped.
    assign accept_en = (state == IDLE) && !coeff_req && !n_rst;
    assign req_ready = grant & {NUM_CH{accept_en}};
    assign accept    = |req_ready;
    assign tmo_hit   = (tmo_cnt == TMO_W'(START_TMO - 1));

    rr_grant #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_rr_grant (
        .clk       (clk),
        .n_rst     (n_rst),
        .req       (req_valid),
        .advance   (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        grant_data = '0;
        for (int j = 0; j < NUM_CH; j++) begin
            if (grant[j]) grant_data = req_data[j];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            state       <= IDLE;
            data_ready  <= 1'b0;
            coeff_start <= 1'b0;
            sample_data <= '0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_err     <= 1'b0;
            res_ch      <= '0;
            tmo_err     <= 1'b0;
            cur_ch      <= '0;
            tmo_cnt     <= '0;
        end else begin
            data_ready  <= 1'b0;
            coeff_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (coeff_req) begin
                        state       <= COEFF_ISSUE;
                        coeff_start <= 1'b1;
                    end else if (accept) begin
                        state       <= ISSUE;
                        data_ready  <= 1'b1;
                        sample_data <= grant_data;
                        cur_ch      <= grant_idx;
                    end
                end
                ISSUE: begin
                    state   <= WAIT_START;
                    tmo_cnt <= '0;
                end
                WAIT_START: begin
                    if (modwait) begin
                        state <= WAIT_DONE;
                    end else if (tmo_hit) begin
                        // Filter never started: return an error result so the requester is not stranded.
                        state     <= RESULT;
                        res_valid <= 1'b1;
                        res_data  <= '0;
                        res_err   <= 1'b1;
                        res_ch    <= cur_ch;
                        tmo_err   <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!modwait) begin
                        state     <= RESULT;
                        res_valid <= 1'b1;
                        res_data  <= fir_out;
                        res_err   <= err;
                        res_ch    <= cur_ch;
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        state     <= IDLE;
                        res_valid <= 1'b0;
                    end
                end
                COEFF_ISSUE: begin
                    state   <= COEFF_WAIT_START;
                    tmo_cnt <= '0;
                end
                COEFF_WAIT_START: begin
                    if (modwait) begin
                        state <= COEFF_WAIT_DONE;
                    end else if (tmo_hit) begin
                        state   <= IDLE;
                        tmo_err <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                COEFF_WAIT_DONE: begin
                    if (!modwait) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_channel_arbiter.sv
// Directed and randomized checks of fir_channel_arbiter against a behavioural scheduling model.
module tb_fir_channel_arbiter;

    localparam int NUM_CH    = 2;
    localparam int CH_W      = 2;
    localparam int START_TMO = 4;

    logic                      clk;
    logic                      n_rst;
    logic [NUM_CH-1:0]         req_valid;
    logic [NUM_CH-1:0][15:0]   req_data;
    logic [NUM_CH-1:0]         req_ready;
    logic                      coeff_req;
    logic                      coeff_start;
    logic                      modwait;
    logic [15:0]               fir_out;
    logic                      err;
    logic [15:0]               sample_data;
    logic                      data_ready;
    logic                      res_valid;
    logic [15:0]               res_data;
    logic                      res_err;
    logic [CH_W-1:0]           res_ch;
    logic                      res_ready;
    logic                      tmo_err;

    int n_tests = 0;
    int n_fail  = 0;
    int last_ch;
    bit exp_tmo;

    fir_channel_arbiter #(
        .NUM_CH    (NUM_CH),
        .CH_W      (CH_W),
        .START_TMO (START_TMO)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .coeff_req   (coeff_req),
        .coeff_start (coeff_start),
        .modwait     (modwait),
        .fir_out     (fir_out),
        .err         (err),
        .sample_data (sample_data),
        .data_ready  (data_ready),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .res_err     (res_err),
        .res_ch      (res_ch),
        .res_ready   (res_ready),
        .tmo_err     (tmo_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: first valid channel strictly after the last one served.
    function automatic int next_ch(input logic [NUM_CH-1:0] v, input int last);
        for (int i = 1; i <= NUM_CH; i++) begin
            int c;
            c = (last + i) % NUM_CH;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic check_reset_outputs(input string tag);
        #1;
        check({tag, "_req_ready"},   req_ready,   0);
        check({tag, "_data_ready"},  data_ready,  0);
        check({tag, "_coeff_start"}, coeff_start, 0);
        check({tag, "_sample_data"}, sample_data, 0);
        check({tag, "_res_valid"},   res_valid,   0);
        check({tag, "_res_data"},    res_data,    0);
        check({tag, "_res_err"},     res_err,     0);
        check({tag, "_res_ch"},      res_ch,      0);
        check({tag, "_tmo_err"},     tmo_err,     0);
    endtask

    task automatic do_reset();
        n_rst = 1'b1;
        @(negedge clk);
        n_rst   = 1'b0;
        last_ch = NUM_CH - 1;
        exp_tmo = 1'b0;
    endtask

    task automatic wait_grant(input int exp_ch, input int max_wait, output int waited);
        waited = 0;
        #1;
        while (req_ready == '0 && waited < max_wait) begin
            @(negedge clk);
            #1;
            waited++;
        end
        check("grant", req_ready, 32'(1) << exp_ch);
    endtask

    // Called in the accept cycle T; returns in the first IDLE cycle after the result is taken.
    task automatic run_txn(input logic [15:0] exp_data, input int exp_ch, input int busy,
                           input logic [15:0] fir, input logic e, input int rr_hold,
                           input bit tmo, input logic [NUM_CH-1:0] valid_after);
        int          rise;
        logic [15:0] exp_res;
        logic        exp_err;
        rise    = tmo ? 2 + START_TMO : 3 + busy;
        exp_res = tmo ? 16'h0 : fir;
        exp_err = tmo ? 1'b1 : e;
        @(negedge clk);
        req_valid = valid_after;
        check("data_ready_pulse", data_ready, 1);
        check("sample_data", sample_data, exp_data);
        if (!tmo) modwait = 1'b1;
        for (int k = 2; k < rise; k++) begin
            @(negedge clk);
            if (!tmo && k == busy + 2) begin
                modwait = 1'b0;
                fir_out = fir;
                err     = e;
            end
            if (rr_hold == 0 && k == rise - 1) res_ready = 1'b1;
            #1;
            check("busy_no_result", res_valid, 0);
            check("busy_no_grant", req_ready, 0);
            check("busy_tmo_err", tmo_err, exp_tmo);
            if (k == 2) check("data_ready_single", data_ready, 0);
        end
        @(negedge clk);
        if (tmo) exp_tmo = 1'b1;
        check("res_valid_rise", res_valid, 1);
        check("res_data", res_data, exp_res);
        check("res_err", res_err, exp_err);
        check("res_ch", res_ch, exp_ch);
        check("tmo_err", tmo_err, exp_tmo);
        for (int h = 1; h <= rr_hold; h++) begin
            @(negedge clk);
            #1;
            check("hold_res_valid", res_valid, 1);
            check("hold_res_data", res_data, exp_res);
            check("hold_res_ch", res_ch, exp_ch);
            check("hold_no_grant", req_ready, 0);
            check("hold_no_coeff", coeff_start, 0);
        end
        if (rr_hold > 0) res_ready = 1'b1;
        @(negedge clk);
        check("res_released", res_valid, 0);
        check("sample_data_held", sample_data, exp_data);
        res_ready = 1'b0;
    endtask

    initial begin
        int          w;
        int          ec;
        int          busy;
        logic [15:0] d;
        logic [NUM_CH-1:0] mask;

        n_rst     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        coeff_req = 1'b0;
        modwait   = 1'b0;
        fir_out   = '0;
        err       = 1'b0;
        res_ready = 1'b0;
        last_ch   = NUM_CH - 1;
        exp_tmo   = 1'b0;

        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        n_rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("idle");

        // Single channel: ch0 sends 0x0100, filter busy 5 cycles, returns 0x0042.
        req_data[0] = 16'h0100;
        req_valid   = 2'b01;
        ec = next_ch(req_valid, last_ch);
        wait_grant(ec, 5, w);
        last_ch = ec;
        run_txn(16'h0100, ec, 5, 16'h0042, 1'b0, 0, 1'b0, '0);

        // Fairness: both channels held valid across four transactions.
        do_reset();
        req_data[0] = 16'($urandom);
        req_data[1] = 16'($urandom);
        req_valid   = 2'b11;
        for (int i = 0; i < 4; i++) begin
            ec = next_ch(req_valid, last_ch);
            wait_grant(ec, 5, w);
            check("fair_grant_latency", w, 0);
            last_ch = ec;
            run_txn(req_data[ec], ec, $urandom_range(1, 4), 16'($urandom), 1'($urandom),
                    0, 1'b0, 2'b11);
        end
        req_valid = '0;

        // Coefficient request beats a simultaneous sample request.
        @(negedge clk);
        req_data[1] = 16'($urandom);
        req_valid   = 2'b10;
        coeff_req   = 1'b1;
        #1;
        check("coeff_beats_sample", req_ready, 0);
        @(negedge clk);
        check("coeff_start_pulse", coeff_start, 1);
        check("coeff_no_grant", req_ready, 0);
        coeff_req = 1'b0;
        modwait   = 1'b1;
        busy      = 3;
        for (int k = 2; k <= busy + 2; k++) begin
            @(negedge clk);
            if (k == busy + 2) modwait = 1'b0;
            #1;
            check("coeff_start_single", coeff_start, 0);
            check("coeff_busy_no_grant", req_ready, 0);
        end
        @(negedge clk);
        ec = next_ch(req_valid, last_ch);
        wait_grant(ec, 0, w);
        last_ch = ec;
        run_txn(req_data[ec], ec, 2, 16'($urandom), 1'b0, 0, 1'b0, '0);

        // Backpressure: result held 10 cycles while ch1 waits.
        req_data[0] = 16'($urandom);
        req_data[1] = 16'($urandom);
        req_valid   = 2'b01;
        ec = next_ch(req_valid, last_ch);
        wait_grant(ec, 5, w);
        last_ch = ec;
        run_txn(req_data[ec], ec, 3, 16'($urandom), 1'b1, 10, 1'b0, 2'b10);
        ec = next_ch(req_valid, last_ch);
        wait_grant(ec, 0, w);
        last_ch = ec;
        run_txn(req_data[ec], ec, 1, 16'($urandom), 1'b0, 0, 1'b0, '0);

        // Timeout: filter never raises modwait.
        req_data[0] = 16'($urandom);
        req_valid   = 2'b01;
        ec = next_ch(req_valid, last_ch);
        wait_grant(ec, 5, w);
        last_ch = ec;
        run_txn(req_data[ec], ec, 1, 16'hFFFF, 1'b0, 0, 1'b1, '0);
        req_data[1] = 16'($urandom);
        req_valid   = 2'b10;
        ec = next_ch(req_valid, last_ch);
        wait_grant(ec, 5, w);
        last_ch = ec;
        run_txn(req_data[ec], ec, 2, 16'($urandom), 1'b0, 1, 1'b0, '0);

        // Reset during WAIT_DONE discards the transaction.
        req_data[0] = 16'($urandom);
        req_valid   = 2'b01;
        ec = next_ch(req_valid, last_ch);
        wait_grant(ec, 5, w);
        @(negedge clk);
        req_valid = '0;
        modwait   = 1'b1;
        repeat (2) @(negedge clk);
        n_rst   = 1'b1;
        modwait = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        n_rst   = 1'b0;
        last_ch = NUM_CH - 1;
        exp_tmo = 1'b0;
        repeat (2) begin
            @(negedge clk);
            #1;
            check("midrst_no_replay", res_valid, 0);
            check("midrst_no_issue", data_ready, 0);
        end
        req_data[0] = 16'($urandom);
        req_data[1] = 16'($urandom);
        req_valid   = 2'b11;
        ec = next_ch(req_valid, last_ch);
        wait_grant(ec, 5, w);
        last_ch = ec;
        run_txn(req_data[ec], ec, 4, 16'($urandom), 1'($urandom), 0, 1'b0, '0);

        // Randomized traffic against the round-robin model.
        for (int i = 0; i < 20; i++) begin
            mask = NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1));
            for (int c = 0; c < NUM_CH; c++) req_data[c] = 16'($urandom);
            req_valid = mask;
            ec = next_ch(mask, last_ch);
            d  = req_data[ec];
            wait_grant(ec, 5, w);
            last_ch = ec;
            run_txn(d, ec, $urandom_range(1, 6), 16'($urandom), 1'($urandom),
                    $urandom_range(0, 3), 1'b0, '0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_channel_arbiter.md
# fir_channel_arbiter

Scheduler that shares one FIR filter datapath between several sample streams and the coefficient loader. Each requester offers 16-bit samples on a valid/ready handshake. The arbiter grants requesters round-robin, drives `sample_data`/`data_ready` into the filter, tracks `modwait` to completion and returns `fir_out`/`err` tagged with the requester's channel. Coefficient reloads are interleaved only between samples. It sits between the bus slave and the filter/loader pair in the top-level FIR wrapper.

## Interface
- `NUM_CH`, 2: number of sample requesters, legal range 2..4.
- `CH_W`, 2: width of the channel tag; must satisfy 2^CH_W ≥ NUM_CH.
- `START_TMO`, 4: maximum number of cycles to wait for `modwait` to rise after a start.
- `clk`  in  1  system clock; all logic is rising-edge.
- `n_rst`  in  1  reset; synchronous, active-high (1 = reset).
- `req_valid`  in  NUM_CH  per-channel sample offered.
- `req_data`  in  NUM_CH×16  per-channel sample.
- `req_ready`  out  NUM_CH  per-channel accept; at most one bit high in any cycle.
- `coeff_req`  in  1  coefficient set pending (level).
- `coeff_start`  out  1  one-cycle pulse that starts a coefficient load.
- `modwait`  in  1  filter/loader busy.
- `fir_out`  in  16  filter result.
- `err`  in  1  filter overflow/error.
- `sample_data`  out  16  sample to the filter.
- `data_ready`  out  1  one-cycle sample strobe.
- `res_valid`, `res_data[15:0]`, `res_err`, `res_ch[CH_W-1:0]`  out  result channel.
- `res_ready`  in  1  result consumer accept.
- `tmo_err`  out  1  sticky flag: the filter never started; cleared only by reset.

## Operation
- FSM states:
  - IDLE → COEFF_ISSUE if `coeff_req`.
  - IDLE → ISSUE if any granted `req_valid`.
  - ISSUE → WAIT_START.
  - WAIT_START → WAIT_DONE on `modwait` = 1.
  - WAIT_START → RESULT on timeout, with `tmo_err` set.
  - WAIT_DONE → RESULT on `modwait` = 0.
  - RESULT → IDLE on `res_ready`.
  - COEFF_ISSUE → COEFF_WAIT_START → COEFF_WAIT_DONE → IDLE.
  - COEFF_WAIT_START times out to IDLE with `tmo_err` set.
- Priority in IDLE: `coeff_req` beats every sample request. Sample channels are round-robin, starting from the channel after the last one granted. The pointer resets to channel NUM_CH-1, so channel 0 is granted first.
- Handshake: `req_ready[g]` = 1 only in IDLE, only for the granted channel g, and only when `coeff_req` = 0 and `req_valid[g]` = 1. The sample transfers on that edge, and the arbiter latches the sample and g.
- ISSUE: `data_ready` = 1 for exactly one cycle, with `sample_data` = the latched sample.
- `sample_data` holds its value until the next grant.
- WAIT_DONE: on the first cycle with `modwait` = 0, capture `fir_out` → `res_data`, `err` → `res_err`, and g → `res_ch`.
- Timeout result: `res_data` = 0, `res_err` = 1.
- RESULT: `res_valid` = 1 with stable payload until `res_ready`. While the result is unaccepted, no new grant and no coefficient start are issued.
- COEFF_ISSUE: `coeff_start` = 1 for one cycle.
- Reset mid-operation: the FSM returns to IDLE; any in-flight sample or result is discarded and nothing is replayed.

## Timing
- Reset values:
  - `req_ready` = 0, `data_ready` = 0, `coeff_start` = 0.
  - `sample_data` = 0, `res_valid` = 0, `res_data` = 0, `res_err` = 0, `res_ch` = 0, `tmo_err` = 0.
  - State = IDLE.
- Latency: accept edge at cycle T; `data_ready` at T+1; WAIT_START from T+2. With `modwait` high from T+2 for N cycles, `res_valid` rises at T+3+N.
- `req_ready` is combinational from state, pointer and `req_valid`. All other outputs are registered.
- Timeout: `modwait` still 0 after START_TMO cycles in WAIT_START → `tmo_err` set.
- Simultaneous events:
  - `coeff_req` and `req_valid` rising in the same IDLE cycle → the coefficient load wins, and the sample waits.
  - `res_ready` arriving in the same cycle `res_valid` rises → accepted, and the FSM is back in IDLE the next cycle.
  - A grant can occur in the first IDLE cycle after RESULT.

## Structure
- Shared package `fir_arb_pkg`:
  - state enum `arb_state_t`.
  - `SAMPLE_W` = 16.
  - default `START_TMO`.
- Sub-module `rr_grant`: round-robin priority picker over NUM_CH request bits. It returns a one-hot grant and takes a pointer-advance input.
- FSM, capture registers and timeout counter live in the top module.

## Test plan
- Single channel: ch0 sends 0x0100; `modwait` high for 5 cycles with `fir_out` = 0x0042. Expect `data_ready` at T+1, then `res_valid` with `res_data` = 0x0042, `res_ch` = 0, `res_err` = 0 at T+8.
- Fairness: ch0 and ch1 both hold `req_valid` continuously for 4 transactions. Expect the grant order 0, 1, 0, 1.
- Coefficient priority: `coeff_req` and `req_valid[1]` asserted in the same cycle. Expect `coeff_start` pulsed first and `req_ready[1]` = 0 until `modwait` falls. Expect the sample granted the cycle after the FSM returns to IDLE.
- Backpressure: hold `res_ready` = 0 for 10 cycles while ch1 is valid. Expect the payload stable and `req_ready` = 0 for those cycles; the grant follows `res_ready`.
- Timeout: keep `modwait` = 0 after `data_ready`. After 4 cycles expect `res_valid` with `res_err` = 1, `res_data` = 0, and `tmo_err` sticky at 1.
- Reset mid-operation: assert `n_rst` in WAIT_DONE. The next cycle expects all outputs at reset values, then a clean transaction after release.
